// File: rtl/oled_spi_master.sv
// Buffered SPI serialiser for the PMOD OLED panel.
// Words sharing a dc value go out back-to-back under one cs window.
module oled_spi_master #(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter bit CPOL       = 1'b1,
  parameter int CS_SETUP   = 1,
  parameter int CS_IDLE    = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_data,
  input  logic                           in_dc,
  output logic                           cs,
  output logic                           sclk,
  output logic                           mosi,
  output logic                           dc,
  output logic                           busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int NW   = $clog2(FIFO_DEPTH + 1);
  localparam int BW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int M1   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int CMAX = (M1 > CS_IDLE) ? M1 : CS_IDLE;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t state, nxt;

  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bitcnt;
  logic [CW-1:0]     cnt;
  logic [DATA_W:0]   head;
  logic              phase, push, pop, tick, last, empty;

  assign empty    = fifo_count == '0;
  assign head     = mem[rptr];
  assign in_ready = !reset && fifo_count != NW'(FIFO_DEPTH);
  assign push     = in_valid && in_ready;
  assign tick     = cnt == CW'(CLK_DIV - 1);
  assign last     = bitcnt == BW'(DATA_W - 1);
  assign mosi     = shreg[DATA_W-1];
  assign busy     = state != S_IDLE || !empty;

  always_comb begin
    nxt = state;
    pop = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == CW'(CS_SETUP - 1)) nxt = S_SHIFT;
      end
      S_SHIFT: begin
        // a same-dc head word continues the burst with no gap
        if (tick && phase && last) begin
          if (!empty && head[DATA_W] == dc) pop = 1'b1;
          else nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt == CW'(CS_IDLE - 1)) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= {in_dc, in_data};
        wptr      <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      fifo_count <= fifo_count + NW'(push) - NW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs     <= 1'b1;
      sclk   <= CPOL;
      dc     <= 1'b0;
      shreg  <= '0;
      bitcnt <= '0;
      cnt    <= '0;
      phase  <= 1'b0;
    end else begin
      cs <= !(nxt == S_SETUP || nxt == S_SHIFT);
      if (pop) begin
        shreg <= head[DATA_W-1:0];
        dc    <= head[DATA_W];
      end
      if (state != nxt || state == S_IDLE) cnt <= '0;
      else if (state != S_SHIFT || !tick)  cnt <= cnt + CW'(1);
      else                                 cnt <= '0;
      if (nxt != S_SHIFT) begin
        sclk   <= CPOL;
        phase  <= 1'b0;
        bitcnt <= '0;
      end else if (state != S_SHIFT) begin
        sclk   <= 1'b0;
        phase  <= 1'b0;
        bitcnt <= '0;
      end else if (tick) begin
        phase <= !phase;
        sclk  <= !phase;
        if (phase) begin
          bitcnt <= last ? '0 : bitcnt + BW'(1);
          if (!pop) shreg <= shreg << 1;
        end
      end
    end
  end
endmodule

// File: tb/tb_oled_spi_master.sv
// Bench for oled_spi_master: a bus monitor rebuilds words from sclk/mosi
// and compares them with the queue of words the bench pushed.
module tb_oled_spi_master;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, in_dc = 1'b0;
  logic in_ready, cs, sclk, mosi, dc, busy;
  logic [7:0] in_data = '0;
  logic [4:0] fifo_count;
  logic in_valid0 = 1'b0, in_dc0 = 1'b0;
  logic in_ready0, cs0, sclk0, mosi0, dc0, busy0;
  logic [7:0] in_data0 = '0;
  logic [4:0] fifo_count0;

  int checks = 0;
  int passes = 0;
  logic [8:0] exp_q[$];
  logic [8:0] rx_q[$];
  int win_q[$];
  int gap_q[$];
  int mon_bits = 0, lo_len = 0, hi_len = 0, dc_bad = 0, sclk_bad = 0;
  logic [7:0] mon_sh = '0;
  logic p_sclk = 1'b1, p_cs = 1'b1, p_dc = 1'b0;

  always #5 clk = ~clk;

  oled_spi_master #(.DATA_W(8), .CLK_DIV(2), .FIFO_DEPTH(16), .CPOL(1'b1),
    .CS_SETUP(1), .CS_IDLE(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dc(in_dc), .cs(cs), .sclk(sclk), .mosi(mosi),
    .dc(dc), .busy(busy), .fifo_count(fifo_count));

  oled_spi_master #(.DATA_W(8), .CLK_DIV(1), .FIFO_DEPTH(16), .CPOL(1'b0),
    .CS_SETUP(1), .CS_IDLE(2)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .in_dc(in_dc0), .cs(cs0), .sclk(sclk0), .mosi(mosi0),
    .dc(dc0), .busy(busy0), .fifo_count(fifo_count0));

  // SPI slave view of the mode-3 device: sample on rising sclk while cs low
  always @(negedge clk) begin
    if (reset) begin
      mon_bits = 0; lo_len = 0; hi_len = 0;
      p_sclk = 1'b1; p_cs = 1'b1; p_dc = 1'b0;
    end else begin
      if (!cs) begin
        if (p_cs) begin gap_q.push_back(hi_len); hi_len = 0; end
        lo_len++;
        if (sclk && !p_sclk) begin
          mon_sh = {mon_sh[6:0], mosi};
          mon_bits++;
          if (mon_bits == 8) begin rx_q.push_back({dc, mon_sh}); mon_bits = 0; end
        end
        if (!p_cs && dc !== p_dc) dc_bad++;
      end else begin
        if (!p_cs) begin win_q.push_back(lo_len); lo_len = 0; mon_bits = 0; end
        hi_len++;
        if (sclk !== 1'b1) sclk_bad++;
      end
      p_sclk = sclk; p_cs = cs; p_dc = dc;
    end
  end

  task automatic push(input logic d, input logic [7:0] w, output bit acc);
    in_valid = 1'b1; in_dc = d; in_data = w;
    acc = in_ready;
    if (acc) exp_q.push_back({d, w});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while ((busy || !cs) && n < 3000) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    ok = n < 3000;
  endtask

  task automatic clear_mon();
    exp_q.delete(); rx_q.delete(); win_q.delete(); gap_q.delete();
    dc_bad = 0; sclk_bad = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cs !== 1'b1) $display("FAIL reset_cs got=%b exp=1", cs); else passes++;
    checks++; if (sclk !== 1'b1) $display("FAIL reset_sclk got=%b exp=1", sclk); else passes++;
    checks++; if (mosi !== 1'b0) $display("FAIL reset_mosi got=%b exp=0", mosi); else passes++;
    checks++; if (dc !== 1'b0) $display("FAIL reset_dc got=%b exp=0", dc); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
    checks++; if (fifo_count !== 5'd0) $display("FAIL reset_count got=%0d exp=0", fifo_count); else passes++;
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", in_ready); else passes++;
    checks++; if (sclk0 !== 1'b0) $display("FAIL reset_sclk_cpol0 got=%b exp=0", sclk0); else passes++;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_ready got=%b exp=1", in_ready); else passes++;
  endtask

  task automatic test_single();
    bit acc, ok;
    int n;
    logic [7:0] w;
    logic d;
    clear_mon();
    push(1'b0, 8'hA5, acc);
    checks++; if (fifo_count !== 5'd1) $display("FAIL single_count_push got=%0d exp=1", fifo_count); else passes++;
    @(negedge clk);
    checks++; if (fifo_count !== 5'd0) $display("FAIL single_count_load got=%0d exp=0", fifo_count); else passes++;
    checks++; if (cs !== 1'b0) $display("FAIL single_cs_setup got=%b exp=0", cs); else passes++;
    n = 0;
    while (cs !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++; if (n >= 200) $display("FAIL single_cs_timeout got=%0d exp<200", n); else passes++;
    n = 0;
    while (busy && n < 20) begin n++; @(negedge clk); end
    checks++; if (n != 2) $display("FAIL single_hold_len got=%0d exp=2", n); else passes++;
    wait_idle(ok);
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 9'h0A5)
      $display("FAIL single_word got=%0d/%h exp=1/0a5", rx_q.size(), rx_q.size() ? rx_q[0] : 9'h0); else passes++;
    checks++; if (win_q.size() != 1 || win_q[0] != 33)
      $display("FAIL single_window got=%0d/%0d exp=1/33", win_q.size(), win_q.size() ? win_q[0] : 0); else passes++;
    clear_mon();
    w = 8'($urandom); d = 1'($urandom);
    push(d, w, acc);
    wait_idle(ok);
    checks++; if (!ok || rx_q.size() != 1 || rx_q[0] !== {d, w})
      $display("FAIL single_rand got=%h exp=%h", rx_q.size() ? rx_q[0] : 9'h0, {d, w}); else passes++;
  endtask

  task automatic test_back_to_back();
    bit acc, ok;
    int bad = 0;
    clear_mon();
    for (int i = 0; i < 3; i++) push(1'b1, 8'($urandom), acc);
    wait_idle(ok);
    if (rx_q.size() != exp_q.size()) bad++;
    else foreach (exp_q[i]) if (rx_q[i] !== exp_q[i]) bad++;
    checks++; if (!ok || bad != 0) $display("FAIL b2b_words got=%0d bad exp=0 (rx=%0d)", bad, rx_q.size()); else passes++;
    checks++; if (win_q.size() != 1 || win_q[0] != 97)
      $display("FAIL b2b_window got=%0d/%0d exp=1/97", win_q.size(), win_q.size() ? win_q[0] : 0); else passes++;
    checks++; if (dc_bad != 0) $display("FAIL b2b_dc_stable got=%0d exp=0", dc_bad); else passes++;
  endtask

  task automatic test_dc_switch();
    bit acc, ok;
    clear_mon();
    push(1'b0, 8'hAF, acc);
    push(1'b1, 8'h12, acc);
    wait_idle(ok);
    checks++; if (!ok || rx_q.size() != 2 || rx_q[0] !== 9'h0AF || rx_q[1] !== 9'h112)
      $display("FAIL dcsw_words got=%0d words exp=0af,112", rx_q.size()); else passes++;
    checks++; if (win_q.size() != 2 || win_q[0] != 33 || win_q[1] != 33)
      $display("FAIL dcsw_windows got=%0d exp=2x33", win_q.size()); else passes++;
    checks++; if (gap_q.size() < 2 || gap_q[$] < 2)
      $display("FAIL dcsw_gap got=%0d exp>=2", gap_q.size() ? gap_q[$] : 0); else passes++;
    checks++; if (dc_bad != 0) $display("FAIL dcsw_dc_stable got=%0d exp=0", dc_bad); else passes++;
    checks++; if (sclk_bad != 0) $display("FAIL dcsw_sclk_idle got=%0d exp=0", sclk_bad); else passes++;
  endtask

  task automatic test_fill();
    bit acc, ok;
    int acc_n = 0, maxc = 0, full_bad = 0, bad = 0, n = 0;
    clear_mon();
    for (int i = 0; i < 24; i++) begin
      push(1'b1, 8'($urandom), acc);
      if (acc) acc_n++;
      if (i == 1 && fifo_count !== 5'd1) full_bad++;
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      if (fifo_count == 5'd16 && in_ready) full_bad++;
    end
    checks++; if (acc_n != 17) $display("FAIL fill_accepted got=%0d exp=17", acc_n); else passes++;
    checks++; if (maxc != 16) $display("FAIL fill_max_count got=%0d exp=16", maxc); else passes++;
    checks++; if (full_bad != 0) $display("FAIL fill_ready_full got=%0d exp=0", full_bad); else passes++;
    acc = 1'b0;
    while (!acc && n < 100) begin push(1'b1, 8'($urandom), acc); n++; end
    checks++; if (!acc || fifo_count !== 5'd16)
      $display("FAIL fill_refill got=%0d exp=16", fifo_count); else passes++;
    wait_idle(ok);
    if (rx_q.size() != exp_q.size()) bad++;
    else foreach (exp_q[i]) if (rx_q[i] !== exp_q[i]) bad++;
    checks++; if (!ok || bad != 0 || rx_q.size() != 18)
      $display("FAIL fill_order got=%0d words bad=%0d exp=18 bad=0", rx_q.size(), bad); else passes++;
    checks++; if (win_q.size() != 1 || win_q[0] != 1 + 18 * 32)
      $display("FAIL fill_window got=%0d exp=%0d", win_q.size() ? win_q[0] : 0, 1 + 18 * 32); else passes++;
  endtask

  task automatic test_reset_mid();
    bit acc, ok;
    int n = 0;
    logic [7:0] w;
    logic d;
    clear_mon();
    push(1'b1, 8'($urandom), acc);
    push(1'b1, 8'($urandom), acc);
    while (mon_bits < 3 && n < 200) begin @(negedge clk); n++; end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (cs !== 1'b1 || sclk !== 1'b1 || mosi !== 1'b0)
      $display("FAIL rstmid_pins got=%b%b%b exp=110", cs, sclk, mosi); else passes++;
    checks++; if (fifo_count !== 5'd0 || busy !== 1'b0)
      $display("FAIL rstmid_flush got=%0d/%b exp=0/0", fifo_count, busy); else passes++;
    reset = 1'b0;
    exp_q.delete(); rx_q.delete(); win_q.delete();
    @(negedge clk);
    w = 8'($urandom); d = 1'($urandom);
    push(d, w, acc);
    wait_idle(ok);
    checks++; if (!ok || rx_q.size() != 1 || rx_q[0] !== {d, w})
      $display("FAIL rstmid_next got=%0d/%h exp=1/%h", rx_q.size(), rx_q.size() ? rx_q[0] : 9'h0, {d, w}); else passes++;
  endtask

  task automatic test_random();
    bit acc, ok;
    int bad = 0, runs = 1;
    logic d;
    clear_mon();
    for (int i = 0; i < 8; i++) begin
      d = 1'($urandom);
      push(d, 8'($urandom), acc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    for (int i = 1; i < exp_q.size(); i++) if (exp_q[i][8] != exp_q[i-1][8]) runs++;
    wait_idle(ok);
    if (rx_q.size() != exp_q.size()) bad++;
    else foreach (exp_q[i]) if (rx_q[i] !== exp_q[i]) bad++;
    checks++; if (!ok || bad != 0) $display("FAIL rand_words got=%0d bad exp=0", bad); else passes++;
    checks++; if (win_q.size() != runs) $display("FAIL rand_bursts got=%0d exp=%0d", win_q.size(), runs); else passes++;
    checks++; if (dc_bad != 0 || sclk_bad != 0)
      $display("FAIL rand_protocol got=%0d/%0d exp=0/0", dc_bad, sclk_bad); else passes++;
  endtask

  task automatic test_cpol0();
    int lo = 0, rises = 0, idle_bad = 0;
    logic [7:0] bits = '0;
    logic ps;
    in_valid0 = 1'b1; in_dc0 = 1'b1; in_data0 = 8'h80;
    @(negedge clk);
    in_valid0 = 1'b0;
    ps = sclk0;
    for (int i = 0; i < 100; i++) begin
      if (!cs0) begin
        lo++;
        if (sclk0 && !ps) begin bits = {bits[6:0], mosi0}; rises++; end
      end else if (sclk0) idle_bad++;
      ps = sclk0;
      @(negedge clk);
    end
    checks++; if (rises != 8 || bits !== 8'h80)
      $display("FAIL cpol0_bits got=%0d/%h exp=8/80", rises, bits); else passes++;
    checks++; if (lo != 17) $display("FAIL cpol0_window got=%0d exp=17", lo); else passes++;
    checks++; if (idle_bad != 0) $display("FAIL cpol0_idle got=%0d exp=0", idle_bad); else passes++;
    checks++; if (dc0 !== 1'b1 || busy0 !== 1'b0)
      $display("FAIL cpol0_end got=%b/%b exp=1/0", dc0, busy0); else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_dc_switch();
    test_fill();
    test_reset_mid();
    test_random();
    test_cpol0();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
